// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature: define UART_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 6;
    localparam int DATA_BITS          = 8;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Frame length in bit periods with a single stop bit
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

    // Even parity: XOR of all data bits
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// Single-entry holding register in front of the transmit shifter.
// Accepts a byte whenever empty; the shifter empties it with a one-cycle take pulse.
module uart_tx_hold
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 take,
    output logic [DATA_BITS-1:0] hold_data,
    output logic                 hold_full
);

    logic accept;

    // Ready depends only on the empty flag, never on tx_valid
    assign tx_ready = ~hold_full;
    assign accept   = tx_valid & ~hold_full;

    // Fill on accept, drain on take; a same-edge accept leaves the register full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (take) begin
                hold_full <= 1'b0;
            end
            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Double-buffered UART transmitter: holding register feeding a framing shifter.
// Bit timing comes from the uart_clk enable, OVERSAMPLE pulses per bit.
// Optional feature: define UART_PARITY_EN to insert an even-parity bit before stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int               TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t             state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [2:0]            bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  tx_reg;
    logic [DATA_BITS-1:0]  hold_data;
    logic                  hold_full;
    logic                  bit_end;
    logic                  frame_end;
    logic                  take;
`ifdef UART_PARITY_EN
    logic                  parity_bit;
`endif

    uart_tx_hold u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .take      (take),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    // A bit period ends on the last tick; a frame ends on the last tick of the last stop bit
    assign bit_end   = uart_clk && (tick_cnt == TICK_LAST);
    assign frame_end = bit_end && (state == STOP) && (bit_idx == STOP_LAST);
    assign take      = hold_full && ((uart_clk && state == IDLE) || frame_end);

    assign tx   = tx_reg;
    assign busy = (state != IDLE) || hold_full;

    // Framing FSM, tick counter and shifter; everything advances only on uart_clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_reg     <= 1'b1;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (uart_clk) begin
            case (state)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                    if (hold_full) begin
                        shift_reg  <= hold_data;
`ifdef UART_PARITY_EN
                        parity_bit <= even_parity(hold_data);
`endif
                        tx_reg     <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        tx_reg   <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
`ifdef UART_PARITY_EN
                            tx_reg  <= parity_bit;
                            state   <= PARITY;
`else
                            tx_reg  <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_reg    <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        tx_reg   <= 1'b1;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (hold_full) begin
                                shift_reg  <= hold_data;
`ifdef UART_PARITY_EN
                                parity_bit <= even_parity(hold_data);
`endif
                                tx_reg     <= 1'b0;
                                state      <= START;
                            end else begin
                                tx_reg <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_reg   <= 1'b1;
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 6, uart_clk pulses per bit period.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port uart_clk  input  1  one-clk-wide bit-timing enable at OVERSAMPLE x baud.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, sampled on accept.
REQ-007 SHALL have port tx_valid  input  1  producer has a byte.
REQ-008 SHALL have port tx_ready  output  1  holding register empty; byte accepted on the clk edge with tx_valid && tx_ready.
REQ-009 SHALL have port tx  output  1  registered serial output, idle high.
REQ-010 SHALL have port busy  output  1  high whenever a frame is in progress or the holding register is full.

Function
REQ-011 SHALL be double-buffered: one holding register plus one shift register, so back-to-back bytes produce frames with no idle gap.
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; all state, bit-index and tick-counter changes occur only on edges where uart_clk=1.
REQ-013 SHALL, in IDLE with holding full, on the next uart_clk edge move the byte to the shift register, clear holding, drive tx=0 and enter START.
REQ-014 SHALL hold every bit for exactly OVERSAMPLE uart_clk pulses using a tick counter 0..OVERSAMPLE-1 that wraps at each bit boundary.
REQ-015 SHALL send DATA LSB first, bits 0..7, then PARITY (when compiled in), then STOP_BITS x OVERSAMPLE ticks of tx=1.
REQ-016 SHALL, at the end of the last stop tick, enter START directly if holding is full (tx=0 on that same edge), else IDLE.
REQ-017 SHALL allow accept and holding-to-shift transfer on the same edge; the new byte lands in holding and tx_ready deasserts.
REQ-018 SHALL ignore tx_valid while tx_ready=0; tx_data need not be stable after accept.
REQ-019 SHALL drive tx_ready combinationally from the holding-register-empty flag only (no dependency on tx_valid).
REQ-020 SHALL keep tx unchanged on edges where uart_clk=0.

Reset
REQ-021 SHALL, on any edge with rst_n=0, set state=IDLE, tx=1, tx_ready=1, busy=0, holding empty, counters 0.
REQ-022 SHALL, on reset mid-frame, abort the frame and drop any held byte; tx=1 from the first reset edge.
REQ-023 SHALL not accept a byte on an edge with rst_n=0.

Configuration
REQ-024 SHALL, with macro UART_PARITY_EN defined, send one even-parity bit (XOR of the 8 data bits) between DATA and STOP (11-bit frame with STOP_BITS=1).
REQ-025 SHALL, without UART_PARITY_EN, skip PARITY entirely; the state is unreachable and the frame is 10 bits.

Structure
REQ-026 SHALL place the FSM state typedef, the default OVERSAMPLE constant (6), and data/frame width constants in shared package uart_pkg.
REQ-027 SHALL factor the holding register with its valid/ready logic into sub-module uart_tx_hold; the FSM, shifter and tick counter remain in uart_tx.

Verification
REQ-028 SHALL cover: uart_clk every 31 clk, no parity, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 186 clk, then idle high, busy low.
REQ-029 SHALL cover: UART_PARITY_EN, send 0x55 -> parity bit 0; send 0x07 -> parity bit 1; stop bit follows.
REQ-030 SHALL cover: two bytes 0xA5, 0x3C offered back-to-back -> second accepted during first frame, no idle tick between the frames.
REQ-031 SHALL cover: STOP_BITS=2 -> stop high for 2 x OVERSAMPLE ticks before the next start bit.
REQ-032 SHALL cover: rst_n low during DATA bit 3 with holding full -> tx=1, tx_ready=1, busy=0 on the first reset edge; the held byte is never sent.
REQ-033 SHALL cover: tx_valid held high with uart_clk tied low -> one byte accepted, tx_ready=0, tx stays 1, busy=1.
